muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_data_1,
    input  logic [XLEN-1:0] i_data_2,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic            accept;
    logic            last;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res_fin;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign accept  = i_valid && o_ready && !i_kill;
    assign last    = (cnt_q == CW'(XLEN-1));

    // Operand signedness follows funct3: MULH/MULHSU sign rs1, DIV/REM sign both.
    always_comb begin
        a_signed = i_op[2] ? !i_op[0] : (i_op[1] ^ i_op[0]);
        b_signed = i_op[2] ? !i_op[0] : (i_op[1:0] == 2'b01);
        a_neg    = a_signed && i_data_1[XLEN-1];
        b_neg    = b_signed && i_data_2[XLEN-1];
        a_mag    = a_neg ? -i_data_1 : i_data_1;
        b_mag    = b_neg ? -i_data_2 : i_data_2;
        div_zero = (i_data_2 == '0);
        div_ovf  = !i_op[0] && (i_data_1 == MIN_NEG) && (&i_data_2);
        special  = i_op[2] && (!ENABLE_DIV || div_zero || div_ovf);
        if (!ENABLE_DIV) begin
            spec_res = '0;
        end else if (div_zero) begin
            spec_res = i_op[1] ? i_data_1 : '1;
        end else begin
            spec_res = i_op[1] ? '0 : i_data_1;
        end
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, opnd_q};
        if (div_diff[XLEN]) begin
            div_nxt = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        acc_nxt = op_q[2] ? div_nxt : mul_nxt;
    end

    // Sign fix-up on the final iteration's value, so the result lands with DONE.
    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = neg_r_q ? -acc_nxt[2*XLEN-1:XLEN]
                       : acc_nxt[2*XLEN-1:XLEN];
        unique case (1'b1)
            op_q == 3'b000:                   res_fin = prod[XLEN-1:0];
            !op_q[2] && op_q[1:0] != 2'b00:   res_fin = prod[2*XLEN-1:XLEN];
            op_q[2] && !op_q[1]:              res_fin = quo;
            op_q[2] && op_q[1]:               res_fin = rem;
            default:                          res_fin = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (i_kill) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            o_result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= i_op;
                neg_q   <= a_neg ^ b_neg;
                neg_r_q <= a_neg;
                cnt_q   <= '0;
                opnd_q  <= i_op[2] ? b_mag : a_mag;
                acc_q   <= {{XLEN{1'b0}}, i_op[2] ? a_mag : b_mag};
                if (special) begin
                    o_result <= spec_res;
                end
            end else if (state == BUSY && !i_kill) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    o_result <= res_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit (XLEN=32).
// Expected values come from a plain-arithmetic model of RV32M.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            i_valid;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_data_1;
    logic [XLEN-1:0] i_data_2;
    logic            i_kill;
    logic            o_ready;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(
        .XLEN      (XLEN),
        .ENABLE_DIV(1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_data_1(i_data_1),
        .i_data_2(i_data_2),
        .i_kill  (i_kill),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_result(o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        bit ovf;
        ovf = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op[2] && (b == 0 || ovf)) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        i_valid  = 1'b1;
        i_op     = op;
        i_data_1 = a;
        i_data_2 = b;
        @(negedge clk);
        i_valid  = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit junk);
        int lat;
        bit seen;
        for (int k = 0; k < 200 && !o_ready; k++) @(negedge clk);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        issue(op, a, b);
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            if (junk && k < 10) begin
                i_valid  = 1'b1;
                i_op     = 3'($urandom_range(0, 7));
                i_data_1 = $urandom;
                i_data_2 = $urandom;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        i_valid = 1'b0;
        check({tag, "_valid"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_result"}, 64'(o_result), 64'(exp));
            check({tag, "_latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
            @(negedge clk);
            check({tag, "_idle"}, {62'd0, o_valid, o_ready}, 64'd1);
        end
    endtask

    initial begin
        logic [31:0] prev;
        bit          seen;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_op     = '0;
        i_data_1 = '0;
        i_data_2 = '0;
        i_kill   = 1'b0;
        #1;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        do_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        do_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
        do_op("divu_z", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_z", 3'd6, 32'd100, 32'd0, 32'd100, 1'b0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 1'b0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // kill in IDLE alongside a request: nothing accepted
        @(negedge clk);
        i_valid  = 1'b1;
        i_kill   = 1'b1;
        i_op     = 3'd0;
        i_data_1 = 32'd9;
        i_data_2 = 32'd9;
        @(negedge clk);
        i_valid = 1'b0;
        i_kill  = 1'b0;
        check("idle_kill_ready", 64'(o_ready), 64'd1);
        check("idle_kill_valid", 64'(o_valid), 64'd0);

        // kill at cycle 10 of a divide
        issue(3'd4, 32'd1000, 32'd7);
        repeat (8) @(negedge clk);
        prev   = o_result;
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        check("kill_ready", 64'(o_ready), 64'd1);
        check("kill_result", 64'(o_result), 64'(prev));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        check("kill_novalid", 64'(seen), 64'd0);
        check("kill_result_after", 64'(o_result), 64'(prev));
        do_op("mul_3x5", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

        // reset pulse in the middle of a multiply
        issue(3'd0, 32'd11, 32'd13);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(o_ready), 64'd1);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_result", 64'(o_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        check("midrst_novalid", 64'(seen), 64'd0);

        // back-to-back random traffic, some with stray requests while busy
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b,
                  ref_model(op, a, b), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
